// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample format, loader state encoding and the
// bit-reversal helper also used by the output reader and butterfly
// address generators.
package fft_pkg;

    localparam int WORD_SIZE = 16;

    // One complex sample, real part in the upper half.
    typedef logic [2*WORD_SIZE-1:0] sample_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Reverse the low 'width' bits of value; bits above width come back 0.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[i] = value[width-1-i];
            end else begin
                result[i] = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_input_loader.sv
// FFT ingest stage: accepts a serial stream of complex samples, pairs each
// even/odd sample and writes the pair into the dual-port sample RAM in one
// cycle at natural or bit-reversed addresses. done pulses once the whole
// frame is resident.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N             = 32,
    parameter int word_size     = WORD_SIZE,
    parameter int address_width = $clog2(N),
    parameter bit BIT_REVERSE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [2*word_size-1:0]   in_samp,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [address_width-1:0] wr_addr1,
    output logic [address_width-1:0] wr_addr2,
    output logic [2*word_size-1:0]   wr_samp1,
    output logic [2*word_size-1:0]   wr_samp2,
    output logic                     busy,
    output logic                     done
);

    localparam logic [address_width:0] LAST_IDX = (address_width+1)'(N - 1);
    localparam logic [address_width:0] CNT_ONE  = (address_width+1)'(1);

    state_e                   state_q, state_d;
    logic [address_width:0]   cnt_q, cnt_d;
    logic [2*word_size-1:0]   hold_q, hold_d;
    logic                     wr_en_q, wr_en_d;
    logic [address_width-1:0] wr_addr1_q, wr_addr1_d;
    logic [address_width-1:0] wr_addr2_q, wr_addr2_d;
    logic [2*word_size-1:0]   wr_samp1_q, wr_samp1_d;
    logic [2*word_size-1:0]   wr_samp2_q, wr_samp2_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     accept_s;
    logic [address_width-1:0] idx_odd_s;
    logic [address_width-1:0] idx_even_s;

    // Map a sample index to its RAM address.
    function automatic logic [address_width-1:0] map_addr(input logic [address_width-1:0] idx);
        logic [31:0] wide;
        logic [31:0] mapped;
        wide = 32'(idx);
        if (BIT_REVERSE) begin
            mapped = bitrev(wide, address_width);
        end else begin
            mapped = wide;
        end
        return mapped[address_width-1:0];
    endfunction

    assign in_ready   = (state_q == ST_LOAD);
    assign accept_s   = in_valid && (state_q == ST_LOAD);
    // On an odd acceptance the counter holds the odd index; its pair partner
    // is the same index with bit 0 cleared.
    assign idx_odd_s  = cnt_q[address_width-1:0];
    assign idx_even_s = {idx_odd_s[address_width-1:1], 1'b0};

    // Next-state logic: frame arming, sample pairing and pair writes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        wr_en_d    = 1'b0;
        wr_addr1_d = wr_addr1_q;
        wr_addr2_d = wr_addr2_q;
        wr_samp1_d = wr_samp1_q;
        wr_samp2_d = wr_samp2_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q[0] == 1'b0) begin
                        hold_d = in_samp;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_samp1_d = hold_q;
                        wr_samp2_d = in_samp;
                        wr_addr1_d = map_addr(idx_even_s);
                        wr_addr2_d = map_addr(idx_odd_s);
                    end
                    // The last sample closes the frame at the same edge, so
                    // in_ready drops before any sample N could be taken.
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr1_q <= '0;
            wr_addr2_q <= '0;
            wr_samp1_q <= '0;
            wr_samp2_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            wr_en_q    <= wr_en_d;
            wr_addr1_q <= wr_addr1_d;
            wr_addr2_q <= wr_addr2_d;
            wr_samp1_q <= wr_samp1_d;
            wr_samp2_q <= wr_samp2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr1 = wr_addr1_q;
    assign wr_addr2 = wr_addr2_q;
    assign wr_samp1 = wr_samp1_q;
    assign wr_samp2 = wr_samp2_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: two N=8 instances (natural and bit-reversed
// addressing) share one input stream. A frame-level reference model predicts
// every output each cycle; fixed pair tables pin down the write sequence.
module tb_fft_input_loader;

    localparam int NS = 8;
    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_samp;

    logic          rdy0, we0, busy0, done0;
    logic [AW-1:0] a10, a20;
    logic [31:0]   s10, s20;
    logic          rdy1, we1, busy1, done1;
    logic [AW-1:0] a11, a21;
    logic [31:0]   s11, s21;

    fft_input_loader #(.N(NS), .word_size(16), .address_width(AW), .BIT_REVERSE(1'b0)) u_nat (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_samp(in_samp),
        .in_ready(rdy0), .wr_en(we0), .wr_addr1(a10), .wr_addr2(a20),
        .wr_samp1(s10), .wr_samp2(s20), .busy(busy0), .done(done0)
    );

    fft_input_loader #(.N(NS), .word_size(16), .address_width(AW), .BIT_REVERSE(1'b1)) u_rev (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_samp(in_samp),
        .in_ready(rdy1), .wr_en(we1), .wr_addr1(a11), .wr_addr2(a21),
        .wr_samp1(s11), .wr_samp2(s21), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: is a frame open, how many samples taken, and
    // what the outputs should show after the coming edge.
    bit          m_load;
    int          m_cnt;
    logic [31:0] m_hold;
    bit          e_we, e_done;
    logic [31:0] e_s1, e_s2;
    int          e_a1n, e_a2n, e_a1r, e_a2r;

    // Captured writes of the current frame.
    int          cap_n;
    int          cap_a1n[16], cap_a2n[16], cap_a1r[16], cap_a2r[16];
    logic [31:0] cap_s1[16], cap_s2[16];

    typedef struct {
        int          a1n, a2n, a1r, a2r;
        logic [31:0] s1, s2;
    } pair_t;
    pair_t exp_pairs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rev3(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input bit rst_n, input bit st, input bit v, input logic [31:0] s);
        reset = rst_n; start = st; in_valid = v; in_samp = s;
        e_we = 1'b0; e_done = 1'b0;
        if (!rst_n) begin
            m_load = 1'b0; m_cnt = 0; m_hold = 32'd0;
            e_s1 = 32'd0; e_s2 = 32'd0;
            e_a1n = 0; e_a2n = 0; e_a1r = 0; e_a2r = 0;
        end else if (!m_load) begin
            if (st) begin
                m_load = 1'b1;
                m_cnt  = 0;
            end
        end else if (v) begin
            if (m_cnt % 2 == 0) begin
                m_hold = s;
            end else begin
                e_we  = 1'b1;
                e_s1  = m_hold;
                e_s2  = s;
                e_a1n = m_cnt - 1;      e_a2n = m_cnt;
                e_a1r = rev3(m_cnt - 1); e_a2r = rev3(m_cnt);
            end
            if (m_cnt == NS - 1) begin
                e_done = 1'b1;
                m_load = 1'b0;
            end
            m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("nat_ready", rdy0, m_load);   chk("rev_ready", rdy1, m_load);
        chk("nat_busy", busy0, m_load);   chk("rev_busy", busy1, m_load);
        chk("nat_done", done0, e_done);   chk("rev_done", done1, e_done);
        chk("nat_wr_en", we0, e_we);      chk("rev_wr_en", we1, e_we);
        chk("nat_addr1", a10, e_a1n);     chk("nat_addr2", a20, e_a2n);
        chk("rev_addr1", a11, e_a1r);     chk("rev_addr2", a21, e_a2r);
        chk("nat_samp1", s10, e_s1);      chk("nat_samp2", s20, e_s2);
        chk("rev_samp1", s11, e_s1);      chk("rev_samp2", s21, e_s2);
        if (we0 === 1'b1 && cap_n < 16) begin
            cap_a1n[cap_n] = a10; cap_a2n[cap_n] = a20;
            cap_a1r[cap_n] = a11; cap_a2r[cap_n] = a21;
            cap_s1[cap_n]  = s10; cap_s2[cap_n]  = s20;
            cap_n++;
        end
    endtask

    // Sample stream 1..8, either back to back or with two idle cycles inside
    // every pair and one after it.
    task automatic send_frame(input bit gaps);
        for (int p = 0; p < NS / 2; p++) begin
            step(1'b1, 1'b0, 1'b1, 32'(2 * p + 1));
            if (gaps) begin
                step(1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
                step(1'b1, 1'b0, 1'b0, 32'hDEAD_0001);
            end
            step(1'b1, 1'b0, 1'b1, 32'(2 * p + 2));
            if (gaps) step(1'b1, 1'b0, 1'b0, 32'hDEAD_0002);
        end
    endtask

    task automatic check_table(input string tag);
        chk({tag, "_write_count"}, 32'(cap_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_nat_a1"}, 32'(cap_a1n[k]), 32'(exp_pairs[k].a1n));
            chk({tag, "_nat_a2"}, 32'(cap_a2n[k]), 32'(exp_pairs[k].a2n));
            chk({tag, "_rev_a1"}, 32'(cap_a1r[k]), 32'(exp_pairs[k].a1r));
            chk({tag, "_rev_a2"}, 32'(cap_a2r[k]), 32'(exp_pairs[k].a2r));
            chk({tag, "_s1"}, cap_s1[k], exp_pairs[k].s1);
            chk({tag, "_s2"}, cap_s2[k], exp_pairs[k].s2);
        end
    endtask

    initial begin
        exp_pairs[0] = '{a1n: 0, a2n: 1, a1r: 0, a2r: 4, s1: 32'h1, s2: 32'h2};
        exp_pairs[1] = '{a1n: 2, a2n: 3, a1r: 2, a2r: 6, s1: 32'h3, s2: 32'h4};
        exp_pairs[2] = '{a1n: 4, a2n: 5, a1r: 1, a2r: 5, s1: 32'h5, s2: 32'h6};
        exp_pairs[3] = '{a1n: 6, a2n: 7, a1r: 3, a2r: 7, s1: 32'h7, s2: 32'h8};
        m_load = 1'b0; m_cnt = 0; m_hold = 32'd0; cap_n = 0;

        // 1: reset held with in_valid high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h1234_5678);
        chk("reset_in_ready", rdy0, 1'b0);
        chk("reset_busy", busy1, 1'b0);

        // 2/3: back-to-back frame, natural and bit-reversed addresses
        cap_n = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        send_frame(1'b0);
        chk("frame_done_idle", busy0, 1'b0);
        check_table("b2b");
        step(1'b1, 1'b0, 1'b1, 32'd99);   // no frame open: nothing accepted
        chk("no_extra_write", we0, 1'b0);

        // 4: gaps inside and between pairs
        cap_n = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        send_frame(1'b1);
        check_table("gaps");

        // 5: reset after 3 accepted samples, then a clean frame
        cap_n = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'(32'h40 + i));
        step(1'b0, 1'b0, 1'b1, 32'h55);
        step(1'b1, 1'b0, 1'b1, 32'h56);
        step(1'b1, 1'b0, 1'b1, 32'h57);
        chk("abort_write_count", 32'(cap_n), 32'd1);
        chk("abort_busy", busy0, 1'b0);
        cap_n = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        send_frame(1'b0);
        check_table("after_abort");

        // 6: start during LOAD and with the last sample ignored; start right
        // after done opens a new frame
        cap_n = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < NS - 1; i++) step(1'b1, 1'b1, 1'b1, 32'(i + 1));
        step(1'b1, 1'b1, 1'b1, 32'd8);
        chk("start_on_last_done", done0, 1'b1);
        chk("start_on_last_busy", busy0, 1'b0);
        check_table("start_in_load");
        cap_n = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("restart_busy", busy0, 1'b1);
        send_frame(1'b0);
        check_table("restart");

        // Randomized traffic with occasional resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            cap_n = 0;
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
                 $urandom_range(0, 1) == 1, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
